// File: rtl/datapath_p.sv
// datapath_p: parametrised LC-3 style datapath.
//
// This block holds PC, IR, MAR, MDR, an 8-entry register file, the ALU, the
// address adder, the NZP condition codes and BEN. It also contains a
// wait-state memory read sequencer with a timeout, and it detects bus
// contention. The control FSM outside this block drives every load enable,
// gate and mux select.
//
// Ports
//   Clk, Reset_ah          clock; synchronous active-high reset
//   LD_PC .. LD_BEN        register load enables
//   GatePC .. GateMARMUX   bus drivers, expected to be one-hot
//   PCMUX, ADDR2MUX,       source selects for PC, the address adder,
//   ADDR1MUX, DRMUX,       the destination register, the SR1 address,
//   SR1MUX, SR2MUX, ALUK   the second ALU operand and the ALU operation
//   MIO_EN                 1: MDR loads from memory, 0: MDR loads from BUS
//   MEM_RD_DATA/VALID      memory read return; VALID is a one-cycle pulse
//   IR, PC, MAR, MDR       architectural registers
//   BUS                    current bus value (combinational)
//   NZP, BEN               condition codes and branch enable
//   MDR_BUSY               a memory read is in flight
//   MEM_ERR, BUS_ERR       sticky read-timeout and bus-contention flags
//
// Read sequencer states
//   state  | meaning
//   S_IDLE | no read outstanding; LD_MDR with MIO_EN=1 starts a read
//   S_WAIT | waiting for MEM_RD_VALID; times out after MEM_TIMEOUT cycles

module datapath_p #(
  parameter int W           = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         Clk,
  input  logic         Reset_ah,
  input  logic         LD_PC,
  input  logic         LD_IR,
  input  logic         LD_MAR,
  input  logic         LD_MDR,
  input  logic         LD_REG,
  input  logic         LD_CC,
  input  logic         LD_BEN,
  input  logic         GatePC,
  input  logic         GateMDR,
  input  logic         GateALU,
  input  logic         GateMARMUX,
  input  logic [1:0]   PCMUX,
  input  logic [1:0]   ADDR2MUX,
  input  logic         ADDR1MUX,
  input  logic         DRMUX,
  input  logic         SR1MUX,
  input  logic         SR2MUX,
  input  logic [1:0]   ALUK,
  input  logic         MIO_EN,
  input  logic [W-1:0] MEM_RD_DATA,
  input  logic         MEM_RD_VALID,
  output logic [W-1:0] IR,
  output logic [W-1:0] PC,
  output logic [W-1:0] MAR,
  output logic [W-1:0] MDR,
  output logic [W-1:0] BUS,
  output logic [2:0]   NZP,
  output logic         BEN,
  output logic         MDR_BUSY,
  output logic         MEM_ERR,
  output logic         BUS_ERR
);

  // One extra bit so MEM_TIMEOUT=1 still gets a non-zero width.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} rd_state_t;

  logic [W-1:0] pc_q, ir_q, mar_q, mdr_q;
  logic [W-1:0] rf_q [8];
  logic [2:0]   nzp_q;
  logic         ben_q, mem_err_q, bus_err_q;

  rd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         rd_capture, rd_timeout;
  logic         mdr_busy, mdr_from_bus;

  logic [W-1:0] sext5, sext6, sext9, sext11;
  logic [2:0]   sr1_addr, dr_addr;
  logic [W-1:0] sr1_data, sr2_data, alu_b, alu_out;
  logic [W-1:0] addr1, addr2, adder, pc_inc, pc_d;
  logic [3:0]   gates;
  logic         bus_conflict;
  logic [2:0]   nzp_d;
  logic         ben_d;

  // Immediate fields, sign-extended to the datapath width.
  assign sext5  = {{(W-5){ir_q[4]}},   ir_q[4:0]};
  assign sext6  = {{(W-6){ir_q[5]}},   ir_q[5:0]};
  assign sext9  = {{(W-9){ir_q[8]}},   ir_q[8:0]};
  assign sext11 = {{(W-11){ir_q[10]}}, ir_q[10:0]};

  assign sr1_addr = SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign dr_addr  = DRMUX ? 3'd7 : ir_q[11:9];

  // Read ports see the registered array, so a same-cycle write is not
  // forwarded: the old value comes back.
  assign sr1_data = rf_q[sr1_addr];
  assign sr2_data = rf_q[ir_q[2:0]];
  assign alu_b    = SR2MUX ? sext5 : sr2_data;

  always_comb begin
    alu_out = '0;
    unique case (ALUK)
      2'b00: alu_out = sr1_data + alu_b;
      2'b01: alu_out = sr1_data & alu_b;
      2'b10: alu_out = ~sr1_data;
      2'b11: alu_out = sr1_data;
    endcase
  end

  assign addr1 = ADDR1MUX ? sr1_data : pc_q;

  always_comb begin
    addr2 = '0;
    unique case (ADDR2MUX)
      2'b00: addr2 = '0;
      2'b01: addr2 = sext6;
      2'b10: addr2 = sext9;
      2'b11: addr2 = sext11;
    endcase
  end

  assign adder  = addr1 + addr2;
  assign pc_inc = pc_q + {{(W-1){1'b0}}, 1'b1};

  // Bus mux. Anything other than exactly one gate drives zero; a clash of
  // two or more gates is also flagged so the sticky BUS_ERR can latch it.
  assign gates        = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign bus_conflict = (gates & (gates - 4'd1)) != 4'd0;

  always_comb begin
    BUS = '0;
    case (gates)
      4'b1000: BUS = pc_q;
      4'b0100: BUS = mdr_q;
      4'b0010: BUS = alu_out;
      4'b0001: BUS = adder;
      default: BUS = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (PCMUX)
      2'b00: pc_d = pc_inc;
      2'b01: pc_d = BUS;
      2'b10: pc_d = adder;
      2'b11: pc_d = pc_q;
    endcase
  end

  // N, Z, P are mutually exclusive; P only when the bus is neither
  // negative nor zero.
  always_comb begin
    nzp_d    = 3'b000;
    nzp_d[2] = BUS[W-1];
    nzp_d[1] = (BUS == '0);
    nzp_d[0] = !BUS[W-1] && (BUS != '0);
  end

  assign ben_d = (ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) |
                 (ir_q[9] & nzp_q[0]);

  // Read sequencer: state register.
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read sequencer: next state. Valid is tested before the timeout so a
  // response on the last allowed cycle is still captured.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_capture = 1'b0;
    rd_timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (LD_MDR && MIO_EN) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (MEM_RD_VALID) begin
          rd_capture = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          rd_timeout = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Read sequencer: outputs. LD_MDR is only honoured from IDLE.
  always_comb begin
    mdr_busy     = (state_q == S_WAIT);
    mdr_from_bus = (state_q == S_IDLE) && LD_MDR && !MIO_EN;
  end

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      nzp_q     <= 3'b010;
      ben_q     <= 1'b0;
      mem_err_q <= 1'b0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (LD_PC)  pc_q  <= pc_d;
      if (LD_IR)  ir_q  <= BUS;
      if (LD_MAR) mar_q <= BUS;
      if (rd_capture)        mdr_q <= MEM_RD_DATA;
      else if (mdr_from_bus) mdr_q <= BUS;
      if (LD_REG) rf_q[dr_addr] <= BUS;
      if (LD_CC)  nzp_q <= nzp_d;
      if (LD_BEN) ben_q <= ben_d;
      if (rd_timeout)   mem_err_q <= 1'b1;
      if (bus_conflict) bus_err_q <= 1'b1;
    end
  end

  assign IR       = ir_q;
  assign PC       = pc_q;
  assign MAR      = mar_q;
  assign MDR      = mdr_q;
  assign NZP      = nzp_q;
  assign BEN      = ben_q;
  assign MDR_BUSY = mdr_busy;
  assign MEM_ERR  = mem_err_q;
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_datapath_p.sv
module tb_datapath_p;

  logic        Clk = 1'b0;
  logic        Reset_ah;
  logic        LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC, LD_BEN;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN;
  logic [15:0] MEM_RD_DATA;
  logic        MEM_RD_VALID;
  logic [15:0] IR, PC, MAR, MDR, BUS;
  logic [2:0]  NZP;
  logic        BEN, MDR_BUSY, MEM_ERR, BUS_ERR;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];

  datapath_p #(.W(16), .MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_ah(Reset_ah),
    .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ALUK(ALUK),
    .MIO_EN(MIO_EN), .MEM_RD_DATA(MEM_RD_DATA), .MEM_RD_VALID(MEM_RD_VALID),
    .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR), .BUS(BUS), .NZP(NZP),
    .BEN(BEN), .MDR_BUSY(MDR_BUSY), .MEM_ERR(MEM_ERR), .BUS_ERR(BUS_ERR)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] b;
    logic        sr2mux;
    logic [1:0]  aluk;
    logic [15:0] exp_bus;
    logic [2:0]  exp_nzp;
  } alu_vec_t;

  typedef struct {
    logic [15:0] ir;
    logic        addr1;
    logic [1:0]  addr2;
    logic [15:0] exp_mar;
  } adr_vec_t;

  alu_vec_t alu_tab[6];
  adr_vec_t adr_tab[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    LD_PC = 0; LD_IR = 0; LD_MAR = 0; LD_MDR = 0; LD_REG = 0; LD_CC = 0;
    LD_BEN = 0; GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
    PCMUX = 2'b11; ADDR2MUX = 0; ADDR1MUX = 0; DRMUX = 0; SR1MUX = 0;
    SR2MUX = 0; ALUK = 0; MIO_EN = 0; MEM_RD_DATA = 0; MEM_RD_VALID = 0;
  endtask

  // Memory read with immediate valid, leaving val in MDR.
  task automatic load_mdr(input logic [15:0] val);
    clr(); LD_MDR = 1; MIO_EN = 1;
    step();
    clr(); MEM_RD_VALID = 1; MEM_RD_DATA = val;
    step();
    clr();
  endtask

  task automatic load_ir(input logic [15:0] val);
    load_mdr(val);
    GateMDR = 1; LD_IR = 1;
    step();
    clr();
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [15:0] val);
    load_ir({4'b0, r, 9'b0});
    load_mdr(val);
    GateMDR = 1; LD_REG = 1; DRMUX = 0;
    step();
    clr();
  endtask

  // Launches a memory read, pulses valid on WAIT cycle valid_at (0 = never),
  // and tries LD_MDR again during WAIT, which must be ignored.
  task automatic mem_read(input int valid_at, input logic [15:0] data,
                          input int exp_busy, input logic [15:0] exp_mdr,
                          input logic [15:0] hold, input logic exp_err);
    int  busy_cyc;
    bit  done;
    busy_cyc = 0;
    done = 0;
    clr(); LD_MDR = 1; MIO_EN = 1;
    sb_q.push_back(exp_mdr);
    step();
    chk("busy_start", {31'b0, MDR_BUSY}, 1);
    for (int c = 1; c <= 40 && !done; c++) begin
      clr();
      MEM_RD_VALID = (c == valid_at);
      MEM_RD_DATA  = (c == valid_at) ? data : 16'hDEAD;
      if (c == 1) begin LD_MDR = 1; MIO_EN = 1; end
      if (c == 2) begin LD_MDR = 1; MIO_EN = 0; GatePC = 1; end
      step();
      if (c == 2 && MDR_BUSY) chk("mdr_hold_in_wait", MDR, hold);
      if (!MDR_BUSY) begin
        busy_cyc = c;
        done = 1;
      end
    end
    clr();
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL busy_bound: MDR_BUSY still 1 after 40 cycles, required 0");
    end
    chk("busy_cycles", busy_cyc, exp_busy);
    if (sb_q.size() > 0) chk("mdr_read", MDR, sb_q.pop_front());
    chk("mem_err", {31'b0, MEM_ERR}, {31'b0, exp_err});
  endtask

  initial begin
    alu_tab[0] = '{16'h1042, 16'h0005, 16'hFFFA, 1'b0, 2'b00, 16'hFFFF, 3'b100};
    alu_tab[1] = '{16'h107F, 16'h0001, 16'h0000, 1'b1, 2'b00, 16'h0000, 3'b010};
    alu_tab[2] = '{16'h5042, 16'h0F0F, 16'h00FF, 1'b0, 2'b01, 16'h000F, 3'b001};
    alu_tab[3] = '{16'h907F, 16'h00FF, 16'h0000, 1'b0, 2'b10, 16'hFF00, 3'b100};
    alu_tab[4] = '{16'h1042, 16'h1234, 16'h0000, 1'b0, 2'b11, 16'h1234, 3'b001};
    alu_tab[5] = '{16'h106F, 16'h7FF5, 16'h0000, 1'b1, 2'b00, 16'h8004, 3'b100};

    // PC = 1, R1 = 0x7FF5 when this table runs.
    adr_tab[0] = '{16'h0400, 1'b0, 2'b11, 16'hFC01};
    adr_tab[1] = '{16'h01FF, 1'b0, 2'b10, 16'h0000};
    adr_tab[2] = '{16'h001F, 1'b0, 2'b01, 16'h0020};
    adr_tab[3] = '{16'h0040, 1'b1, 2'b00, 16'h7FF5};
    adr_tab[4] = '{16'h0060, 1'b1, 2'b01, 16'h7FD5};

    clr();
    Reset_ah = 1;
    step(); step();
    Reset_ah = 0;
    chk("rst_pc", PC, 0);
    chk("rst_ir", IR, 0);
    chk("rst_mar", MAR, 0);
    chk("rst_mdr", MDR, 0);
    chk("rst_nzp", {29'b0, NZP}, 3'b010);
    chk("rst_flags", {28'b0, BEN, MDR_BUSY, MEM_ERR, BUS_ERR}, 0);
    GateALU = 1; ALUK = 2'b11; #1;
    chk("rst_r0", BUS, 0);
    clr();

    // PC increment, wrap and hold.
    for (int i = 0; i < 3; i++) begin
      LD_PC = 1; PCMUX = 2'b00;
      step();
    end
    clr();
    chk("pc_inc3", PC, 3);
    load_mdr(16'hFFFF);
    GateMDR = 1; PCMUX = 2'b01; LD_PC = 1;
    step(); clr();
    chk("pc_from_bus", PC, 16'hFFFF);
    LD_PC = 1; PCMUX = 2'b00;
    step();
    chk("pc_wrap", PC, 0);
    step();
    chk("pc_inc_after_wrap", PC, 1);
    PCMUX = 2'b11;
    step(); clr();
    chk("pc_hold", PC, 1);

    // ALU and condition codes.
    foreach (alu_tab[i]) begin
      set_reg(3'd1, alu_tab[i].a);
      set_reg(3'd2, alu_tab[i].b);
      load_ir(alu_tab[i].ir);
      SR1MUX = 1; SR2MUX = alu_tab[i].sr2mux; ALUK = alu_tab[i].aluk;
      GateALU = 1; LD_REG = 1; LD_CC = 1;
      #1;
      chk($sformatf("alu_bus[%0d]", i), BUS, alu_tab[i].exp_bus);
      step(); clr();
      chk($sformatf("alu_nzp[%0d]", i), {29'b0, NZP}, alu_tab[i].exp_nzp);
    end

    // Address adder onto MAR.
    foreach (adr_tab[i]) begin
      load_ir(adr_tab[i].ir);
      SR1MUX = 1; ADDR1MUX = adr_tab[i].addr1; ADDR2MUX = adr_tab[i].addr2;
      GateMARMUX = 1; LD_MAR = 1;
      step(); clr();
      chk($sformatf("adder_mar[%0d]", i), MAR, adr_tab[i].exp_mar);
    end

    // BEN against NZP = 100.
    load_ir(16'h0E00); LD_BEN = 1; step(); clr();
    chk("ben_nzp_all", {31'b0, BEN}, 1);
    load_ir(16'h0200); LD_BEN = 1; step(); clr();
    chk("ben_p_only", {31'b0, BEN}, 0);
    load_ir(16'h0800); LD_BEN = 1; step(); clr();
    chk("ben_n_only", {31'b0, BEN}, 1);

    // Register read while the same register is written.
    load_ir(16'h0240);
    SR1MUX = 1; ALUK = 2'b10; GateALU = 1; LD_REG = 1; LD_MAR = 1;
    #1;
    chk("rf_old_value_bus", BUS, 16'h800A);
    step(); clr();
    chk("rf_write_mar", MAR, 16'h800A);
    SR1MUX = 1; ALUK = 2'b11; GateALU = 1; #1;
    chk("rf_new_value", BUS, 16'h800A);
    clr();

    // MDR from bus.
    GatePC = 1; LD_MDR = 1; MIO_EN = 0;
    step(); clr();
    chk("mdr_from_bus", MDR, 16'h0001);
    chk("mdr_bus_no_busy", {31'b0, MDR_BUSY}, 0);

    // Memory reads.
    load_mdr(16'h3000);
    GateMDR = 1; LD_MAR = 1;
    step(); clr();
    chk("mar_3000", MAR, 16'h3000);
    mem_read(3, 16'hBEEF, 3, 16'hBEEF, 16'h3000, 1'b0);
    mem_read(15, 16'hA5A5, 15, 16'hA5A5, 16'hBEEF, 1'b0);
    mem_read(0, 16'h1111, 15, 16'hA5A5, 16'hA5A5, 1'b1);
    MEM_RD_VALID = 1; MEM_RD_DATA = 16'h2222;
    step(); clr();
    chk("late_valid_ignored", MDR, 16'hA5A5);
    chk("late_valid_no_busy", {31'b0, MDR_BUSY}, 0);

    // Bus contention.
    chk("bus_err_clear", {31'b0, BUS_ERR}, 0);
    #1;
    chk("bus_no_gate", BUS, 0);
    GatePC = 1; GateMDR = 1; LD_MAR = 1;
    #1;
    chk("bus_conflict_zero", BUS, 0);
    step(); clr();
    chk("conflict_mar", MAR, 0);
    chk("bus_err_set", {31'b0, BUS_ERR}, 1);
    step(); step(); step();
    chk("bus_err_sticky", {31'b0, BUS_ERR}, 1);

    // Reset in the middle of a read.
    LD_MDR = 1; MIO_EN = 1;
    step(); clr();
    step();
    chk("busy_before_reset", {31'b0, MDR_BUSY}, 1);
    Reset_ah = 1;
    step();
    Reset_ah = 0;
    chk("mid_rst_pc", PC, 0);
    chk("mid_rst_ir", IR, 0);
    chk("mid_rst_mar", MAR, 0);
    chk("mid_rst_mdr", MDR, 0);
    chk("mid_rst_nzp", {29'b0, NZP}, 3'b010);
    chk("mid_rst_flags", {28'b0, BEN, MDR_BUSY, MEM_ERR, BUS_ERR}, 0);
    MEM_RD_VALID = 1; MEM_RD_DATA = 16'h5555;
    step(); clr();
    chk("post_rst_valid_ignored", MDR, 0);
    chk("post_rst_no_busy", {31'b0, MDR_BUSY}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
